// File: rtl/mem_lcd_ctrl_if.sv
// Host/register-file/LCD bus of the LCD refresh controller.
// The slave modport is the controller side; master is the host side.
interface mem_lcd_ctrl_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;

  modport master (
    output start, mem_rd_data,
    input  busy, done, mem_rd_addr, lcd_data, lcd_rs, lcd_rw, lcd_e
  );

  modport slave (
    input  start, mem_rd_data,
    output busy, done, mem_rd_addr, lcd_data, lcd_rs, lcd_rw, lcd_e
  );
endinterface

// File: rtl/mem_lcd_ctrl.sv
// HD44780-style LCD controller: power-up wait, init command sequence, and
// on request a refresh of line 1 from 16 register-file words.
module mem_lcd_ctrl #(
  parameter int E_PULSE_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWR_WAIT_CYC = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  mem_lcd_ctrl_if.slave bus
);

  localparam int MAX_A   = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B   = (CLR_WAIT_CYC > PWR_WAIT_CYC) ? CLR_WAIT_CYC : PWR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT_CYC);
  localparam logic          E_ZERO   = (E_PULSE_CYC == 0);
  localparam logic          CMD_ZERO = (CMD_WAIT_CYC == 0);
  localparam logic          CLR_ZERO = (CLR_WAIT_CYC == 0);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_IDLE     = 3'd2,
    S_SET_ADDR = 3'd3,
    S_CHAR     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP  = 2'd0,
    P_E_HIGH = 2'd1,
    P_E_WAIT = 2'd2
  } phase_t;

  state_t        r_state, w_state;
  phase_t        r_phase, w_phase;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    r_idx, w_idx;
  logic [7:0]    r_data, w_data;
  logic          r_rs, w_rs;

  logic          w_xfer;
  logic          w_is_clr;
  logic          w_wait_zero;
  logic [CW-1:0] w_wait_last;
  logic [7:0]    w_setup_byte;
  logic          w_setup_rs;
  logic          w_xfer_end;
  logic          w_unused_hi;

  assign w_xfer      = (r_state == S_INIT) || (r_state == S_SET_ADDR) || (r_state == S_CHAR);
  assign w_is_clr    = (r_state == S_INIT) && (r_idx == 4'd3);
  assign w_wait_zero = w_is_clr ? CLR_ZERO : CMD_ZERO;
  assign w_wait_last = w_is_clr ? CLR_LAST : CMD_LAST;
  assign w_setup_rs  = (r_state == S_CHAR);
  assign w_unused_hi = ^bus.mem_rd_data[31:8];

  // Byte presented during the SETUP cycle of the current transfer.
  always_comb begin
    w_setup_byte = 8'h00;
    case (r_state)
      S_INIT: begin
        case (r_idx)
          4'd0:    w_setup_byte = 8'h38;
          4'd1:    w_setup_byte = 8'h0C;
          4'd2:    w_setup_byte = 8'h06;
          default: w_setup_byte = 8'h01;
        endcase
      end
      S_SET_ADDR: w_setup_byte = 8'h80;
      S_CHAR:     w_setup_byte = bus.mem_rd_data[7:0];
      default:    w_setup_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PWR_WAIT;
      r_phase <= P_SETUP;
      r_cnt   <= CNT_ZERO;
      r_idx   <= 4'd0;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_rs    <= w_rs;
    end
  end

  // Next state: transfer sub-phase sequencer, then top-level sequencing.
  always_comb begin
    w_state    = r_state;
    w_phase    = r_phase;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_data     = r_data;
    w_rs       = r_rs;
    w_xfer_end = 1'b0;

    if (w_xfer) begin
      case (r_phase)
        P_SETUP: begin
          w_data = w_setup_byte;
          w_rs   = w_setup_rs;
          w_cnt  = CNT_ZERO;
          if (!E_ZERO) begin
            w_phase = P_E_HIGH;
          end else if (!w_wait_zero) begin
            w_phase = P_E_WAIT;
          end else begin
            w_xfer_end = 1'b1;
          end
        end
        P_E_HIGH: begin
          if (r_cnt == E_LAST) begin
            w_cnt = CNT_ZERO;
            if (!w_wait_zero) begin
              w_phase = P_E_WAIT;
            end else begin
              w_xfer_end = 1'b1;
            end
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        P_E_WAIT: begin
          if (r_cnt == w_wait_last) begin
            w_xfer_end = 1'b1;
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        default: w_phase = P_SETUP;
      endcase
    end else begin
      w_phase = r_phase;
    end

    case (r_state)
      S_PWR_WAIT: begin
        if (r_cnt == PWR_LAST) begin
          w_state = S_INIT;
          w_cnt   = CNT_ZERO;
          w_phase = P_SETUP;
          w_idx   = 4'd0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_INIT: begin
        if (w_xfer_end && (r_idx == 4'd3)) begin
          w_state = S_IDLE;
          w_idx   = 4'd0;
        end else if (w_xfer_end) begin
          w_idx = r_idx + 4'd1;
        end else begin
          w_idx = r_idx;
        end
      end
      S_IDLE: begin
        if (bus.start) begin
          w_state = S_SET_ADDR;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SET_ADDR: begin
        if (w_xfer_end) begin
          w_state = S_CHAR;
          w_idx   = 4'd0;
        end else begin
          w_state = S_SET_ADDR;
        end
      end
      S_CHAR: begin
        if (w_xfer_end && (r_idx == 4'd15)) begin
          w_state = S_DONE;
          w_idx   = 4'd0;
        end else if (w_xfer_end) begin
          w_idx = r_idx + 4'd1;
        end else begin
          w_idx = r_idx;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_PWR_WAIT;
    endcase

    if (w_xfer_end) begin
      w_phase = P_SETUP;
      w_cnt   = CNT_ZERO;
    end else begin
      w_phase = w_phase;
    end
  end

  // The address is decoded separately so the read data path has no loop back into this block.
  assign bus.mem_rd_addr = (r_state == S_CHAR) ? r_idx : 4'd0;

  // Outputs; in SETUP the bus shows the byte about to be latched so it is valid a cycle before lcd_e.
  always_comb begin
    bus.busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.done   = (r_state == S_DONE);
    bus.lcd_e  = w_xfer && (r_phase == P_E_HIGH);
    bus.lcd_rw = 1'b0;
    if (w_xfer && (r_phase == P_SETUP)) begin
      bus.lcd_data = w_setup_byte;
      bus.lcd_rs   = w_setup_rs;
    end else begin
      bus.lcd_data = r_data;
      bus.lcd_rs   = r_rs;
    end
  end

endmodule
